// File: rtl/portal_echo_user.sv
// ---------------------------------------------------------------------------
// portal_echo_user
//
// Purpose:
//   Loopback user endpoint that sits directly below the AXI portal top. It
//   collects one request message (a run of 32-bit words ended by 'last')
//   from the write-enqueue channel into a local buffer. It then returns the
//   message on the read-enqueue channel as an indication. The returned
//   header word carries the truncation flag in bit 31 and the stored length
//   in bits 15:0. Payload words are echoed back unchanged.
//
//   Fill and drain never overlap. While a message is being returned, the
//   request channel is held off.
//
// Configuration macro:
//   PORTAL_ECHO_BYTESWAP_EN - when defined, payload words (not the header)
//                             are returned byte-reversed.
//
// Parameters:
//   DEPTH - buffer depth in 32-bit words, header included (power of two)
//   AW    - buffer address width, log2(DEPTH)
//
// Ports:
//   CLK             in   clock, everything on the rising edge
//   RST             in   synchronous active-high reset
//   write_enq__ENA  in   request word valid
//   write_enq_v     in   request word
//   write_enq_last  in   final word of the request message
//   write_enq__RDY  out  block can accept a request word
//   read_enq__ENA   out  indication word valid
//   read_enq_v      out  indication word
//   read_enq_last   out  final word of the indication message
//   read_enq__RDY   in   portal can accept an indication word
//   msg_count       out  number of completed echoes, wraps at 16 bits
//   overflow        out  sticky, some message was truncated
// ---------------------------------------------------------------------------
module portal_echo_user #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        write_enq__ENA,
  input  logic [31:0] write_enq_v,
  input  logic        write_enq_last,
  output logic        write_enq__RDY,
  output logic        read_enq__ENA,
  output logic [31:0] read_enq_v,
  output logic        read_enq_last,
  input  logic        read_enq__RDY,
  output logic [15:0] msg_count,
  output logic        overflow
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [AW:0]   len_q, len_d;
  logic          trunc_q, trunc_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   msgCount_q, msgCount_d;
  logic [31:0]   outWord_q, outWord_d;

  logic [31:0]   mem [DEPTH];
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [AW-1:0] memRaddr;
  logic [31:0]   memRdata;
  logic [31:0]   hdrSrc;
  logic          lastWord;

  // Payload transform applied to words 1..len-1 on their way out. The
  // header never passes through here.
  function automatic logic [31:0] payloadXform(input logic [31:0] w);
`ifdef PORTAL_ECHO_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // The output word is a register. It is loaded one cycle ahead of when
  // it is presented. During FILL, the read address is parked on word 0 so
  // that the header can be built on the cycle that accepts 'last'. During
  // DRAIN, the read address looks one word ahead of rdPtr, so the next
  // payload word is ready the moment the current one is taken.
  assign memRaddr = (state_q == DRAIN) ? (rdPtr_q[AW-1:0] + AW'(1)) : '0;
  assign memRdata = mem[memRaddr];
  assign memWaddr = wrPtr_q[AW-1:0];

  // For a one-word message, word 0 is written on the same edge that the
  // header is built. In that case the header must come straight from the
  // input bus rather than from the buffer.
  assign hdrSrc   = (wrPtr_q == '0) ? write_enq_v : memRdata;

  assign lastWord = (rdPtr_q == (len_q - OneW));

  // Next-state logic for fill/drain sequencing, pointers, header
  // construction and the echo counter. Every target takes its hold value
  // first, and the state-specific branches override it.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    overflow_d = overflow_q;
    msgCount_d = msgCount_q;
    outWord_d  = outWord_q;
    memWe      = 1'b0;

    case (state_q)
      FILL: begin
        if (write_enq__ENA) begin
          // Words beyond the buffer are dropped. Only the flags record
          // that they existed.
          if (wrPtr_q < DepthW) begin
            memWe   = 1'b1;
            wrPtr_d = wrPtr_q + OneW;
          end else begin
            trunc_d    = 1'b1;
            overflow_d = 1'b1;
          end
          if (write_enq_last) begin
            len_d     = (wrPtr_q < DepthW) ? (wrPtr_q + OneW) : DepthW;
            rdPtr_d   = '0;
            state_d   = DRAIN;
            outWord_d = {trunc_d, hdrSrc[30:16], 16'(len_d)};
          end
        end
      end

      DRAIN: begin
        if (read_enq__RDY) begin
          if (lastWord) begin
            state_d    = FILL;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            len_d      = '0;
            trunc_d    = 1'b0;
            msgCount_d = msgCount_q + 16'd1;
            outWord_d  = '0;
          end else begin
            rdPtr_d   = rdPtr_q + OneW;
            outWord_d = payloadXform(memRdata);
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // Control and datapath registers. A reset abandons any message in flight
  // and clears the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= FILL;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      overflow_q <= 1'b0;
      msgCount_q <= '0;
      outWord_q  <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      overflow_q <= overflow_d;
      msgCount_q <= msgCount_d;
      outWord_q  <= outWord_d;
    end
  end

  // Message buffer storage. It has no reset because the pointers define
  // what is valid.
  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[memWaddr] <= write_enq_v;
    end
  end

  // Both handshake strobes come from the state register only. This keeps
  // them free of any combinational path from the opposite ready signal.
  assign write_enq__RDY = (state_q == FILL);
  assign read_enq__ENA  = (state_q == DRAIN);
  assign read_enq_v     = outWord_q;
  assign read_enq_last  = (state_q == DRAIN) && lastWord;
  assign msg_count      = msgCount_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_portal_echo_user.sv
// ---------------------------------------------------------------------------
// tb_portal_echo_user
//
// Self-checking bench for portal_echo_user (DEPTH=16). Request messages are
// driven through the write-enqueue channel. The returned indication is
// compared against a message-level reference model: truncate to DEPTH
// words, rewrite the header, and echo or byte-reverse the payload. The
// model also tracks the expected echo count and the sticky overflow flag.
// ---------------------------------------------------------------------------
module tb_portal_echo_user;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef logic [31:0] word_q[$];

  logic        clk;
  logic        rst;
  logic        wEna;
  logic [31:0] wV;
  logic        wLast;
  logic        wRdy;
  logic        rEna;
  logic [31:0] rV;
  logic        rLast;
  logic        rRdy;
  logic [15:0] msgCount;
  logic        ovf;

  int checks;
  int errors;
  int modelCount;
  bit modelOvf;

  portal_echo_user #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK            (clk),
    .RST            (rst),
    .write_enq__ENA (wEna),
    .write_enq_v    (wV),
    .write_enq_last (wLast),
    .write_enq__RDY (wRdy),
    .read_enq__ENA  (rEna),
    .read_enq_v     (rV),
    .read_enq_last  (rLast),
    .read_enq__RDY  (rRdy),
    .msg_count      (msgCount),
    .overflow       (ovf)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference payload transform.
  function automatic logic [31:0] refPayload(input logic [31:0] w);
`ifdef PORTAL_ECHO_BYTESWAP_EN
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  // Whole-message reference: what the indication must contain for a given
  // request.
  function automatic word_q expectedEcho(input word_q msg);
    word_q r;
    int n = msg.size();
    int len = (n > DEPTH) ? DEPTH : n;
    logic [31:0] h;
    h = msg[0];
    h[31] = (n > DEPTH);
    h[15:0] = 16'(len);
    r.push_back(h);
    for (int i = 1; i < len; i++) r.push_back(refPayload(msg[i]));
    return r;
  endfunction

  // Drive one request message. The task returns on the falling edge just
  // after the last word has been accepted.
  task automatic applyStimulus(input word_q msg);
    for (int i = 0; i < msg.size(); i++) begin
      int guard = 0;
      @(negedge clk);
      while (!wRdy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!wRdy) begin
        checks++;
        errors++;
        $display("[TB] FAIL send_rdy_timeout: got wRdy=%b required 1", wRdy);
      end
      wEna  = 1'b1;
      wV    = msg[i];
      wLast = (i == msg.size() - 1);
      @(posedge clk);
    end
    @(negedge clk);
    wEna  = 1'b0;
    wLast = 1'b0;
    wV    = '0;
  endtask

  // Collect the indication. Call this on the falling edge after the
  // request's last word. rdy mode: 0 = always ready, 1 = pattern 1,0,0,1,
  // 2 = random. stopAt < 0 drains the full message. Otherwise the task
  // stops after that many words and stays in drain.
  task automatic recvMsg(input word_q exp, input int mode, input int stopAt);
    int idx = 0;
    int cyc = 0;
    int target = (stopAt < 0) ? exp.size() : stopAt;
    bit heldValid = 0;
    logic [31:0] heldV = '0;
    logic heldLast = 0;
    bit rdy;
    checks++;
    if (rEna !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_word_latency: got ENA=%b required 1", rEna);
    end
    while (idx < target && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rRdy = rdy;
      checks++;
      if (wRdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL drain_wrdy: got %b required 0", wRdy);
      end
      if (heldValid) begin
        checks++;
        if (rEna !== 1'b1 || rV !== heldV || rLast !== heldLast) begin
          errors++;
          $display("[TB] FAIL held_word: got ena=%b v=%h last=%b required ena=1 v=%h last=%b",
                   rEna, rV, rLast, heldV, heldLast);
        end
      end
      if (rEna) begin
        if (rdy) begin
          checks++;
          if (rV !== exp[idx]) begin
            errors++;
            $display("[TB] FAIL word%0d: got %h required %h", idx, rV, exp[idx]);
          end
          checks++;
          if (rLast !== (idx == exp.size() - 1)) begin
            errors++;
            $display("[TB] FAIL last%0d: got %b required %b", idx, rLast, (idx == exp.size() - 1));
          end
          idx++;
          heldValid = 0;
        end else begin
          heldValid = 1;
          heldV     = rV;
          heldLast  = rLast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rRdy = 1'b0;
    if (idx < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d words required %0d", idx, target);
    end
    if (stopAt < 0) begin
      modelCount++;
      checks++;
      if (msgCount !== 16'(modelCount)) begin
        errors++;
        $display("[TB] FAIL msg_count: got %0d required %0d", msgCount, modelCount);
      end
      checks++;
      if (ovf !== modelOvf) begin
        errors++;
        $display("[TB] FAIL overflow: got %b required %b", ovf, modelOvf);
      end
      checks++;
      if (wRdy !== 1'b1 || rEna !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_drain: got wRdy=%b ENA=%b required 1 0", wRdy, rEna);
      end
    end
  endtask

  // One full echo: drive the request, update the model, check the output.
  task automatic echoOnce(input word_q msg, input int mode);
    modelOvf = modelOvf | (msg.size() > DEPTH);
    applyStimulus(msg);
    recvMsg(expectedEcho(msg), mode, -1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    modelCount = 0;
    modelOvf   = 0;
    checks++;
    if (wRdy !== 1'b1 || rEna !== 1'b0 || rV !== 32'h0 || rLast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got wRdy=%b ENA=%b v=%h last=%b required 1 0 0 0",
               wRdy, rEna, rV, rLast);
    end
    checks++;
    if (msgCount !== 16'd0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: got count=%0d ovf=%b required 0 0", msgCount, ovf);
    end
  endtask

  task automatic test_basic();
    word_q m = '{32'h00050000, 32'h11111111, 32'h22222222};
    echoOnce(m, 0);
  endtask

  task automatic test_single();
    word_q m = '{32'h12340000};
    echoOnce(m, 0);
  endtask

  task automatic test_overflow();
    word_q m;
    word_q c = '{32'h00090000, 32'hCAFEF00D};
    m.push_back(32'h00070000);
    for (int i = 1; i < 20; i++) m.push_back(32'h1000_0000 + i);
    echoOnce(m, 0);
    echoOnce(c, 0);
  endtask

  task automatic test_backpressure();
    word_q m = '{32'h00AB0000, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    echoOnce(m, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      word_q m;
      int n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) m.push_back($urandom());
      echoOnce(m, 2);
    end
  endtask

  task automatic test_reset_mid();
    word_q m = '{32'h00440000, 32'h5555AAAA, 32'h66667777, 32'h88889999};
    word_q m2 = '{32'h00330000, 32'hAABBCCDD};
    modelOvf = modelOvf | (m.size() > DEPTH);
    applyStimulus(m);
    recvMsg(expectedEcho(m), 0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelCount = 0;
    modelOvf   = 0;
    checks++;
    if (rEna !== 1'b0 || msgCount !== 16'd0 || ovf !== 1'b0 || wRdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset: got ENA=%b count=%0d ovf=%b wRdy=%b required 0 0 0 1",
               rEna, msgCount, ovf, wRdy);
    end
    echoOnce(m2, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelCount = 0;
    modelOvf = 0;
    rst   = 1'b1;
    wEna  = 1'b0;
    wV    = '0;
    wLast = 1'b0;
    rRdy  = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
